// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, buffers returned words with their PC in a small FIFO
// and hands them to decode with valid/ready. Redirects flush the buffer and
// turn any outstanding fetch stale so its response is dropped.
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_req_pc;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_ins_mem [DEPTH];

    logic [1:0]    w_state_next;
    logic [31:0]   w_fetch_pc_next;
    logic [CW-1:0] w_count_next;
    logic [31:0]   w_redirect_pc;
    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_empty;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_empty       = (r_count == '0);

    // Next-state, FIFO push/pop and issue decision
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_count_next    = r_count;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_issue         = 1'b0;

        w_push = (r_state == S_WAIT) && imem_rvalid && !redirect_valid;
        w_pop  = !w_empty && instr_ready && !redirect_valid;

        if (redirect_valid) begin
            w_count_next = '0;
        end else begin
            w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        end

        // Issue only when nothing stays outstanding and the reply is sure to fit
        w_issue = rst_n && !redirect_valid &&
                  ((r_state == S_IDLE) || ((r_state == S_WAIT) && imem_rvalid)) &&
                  (w_count_next < CW'(DEPTH));

        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_state_next = imem_rvalid ? S_IDLE : S_DRAIN;
                end else if (imem_rvalid) begin
                    w_state_next = w_issue ? S_WAIT : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (redirect_valid) begin
            w_fetch_pc_next = w_redirect_pc;
        end else if (w_issue) begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
        end
    end

    // Control state: FSM, PCs, FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;
            if (w_issue) begin
                r_req_pc <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
            end
        end
    end

    // Buffer storage; contents are only visible while the entry is counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_req_pc;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = w_issue ? r_fetch_pc : 32'h0;
    assign instr_valid = !w_empty;
    assign instr       = w_empty ? 32'h0 : r_ins_mem[r_rd_ptr];
    assign instr_pc    = w_empty ? 32'h0 : r_pc_mem[r_rd_ptr];

`ifdef FETCH_PERF_EN
    // Fetch/flush statistics; a redirect charges buffered entries plus a live fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (w_push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                perf_flushed <= perf_flushed + 32'(r_count) + 32'(r_state == S_WAIT);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table driving the memory
// response and downstream ready by hand, plus reset and counter sequences.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FETCH_PERF_EN
    logic [31:0] m_perf_fetched;
    logic [31:0] m_perf_flushed;
`endif

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (m_perf_fetched),
        .perf_flushed   (m_perf_flushed)
`endif
    );

`ifdef FETCH_PERF_EN
    // Second instance with a deeper buffer and a 1-cycle memory for the counters
    logic        p_rst_n;
    logic        p_redir;
    logic        p_req;
    logic [31:0] p_addr;
    logic        p_rvalid;
    logic [31:0] p_rdata;
    logic        p_valid;
    logic [31:0] p_instr;
    logic [31:0] p_pc;
    logic        p_rdy;
    logic [31:0] p_fetched;
    logic [31:0] p_flushed;

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u_perf (
        .clk            (clk),
        .rst_n          (p_rst_n),
        .redirect_valid (p_redir),
        .redirect_pc    (32'h0000_0800),
        .imem_req       (p_req),
        .imem_addr      (p_addr),
        .imem_rvalid    (p_rvalid),
        .imem_rdata     (p_rdata),
        .instr_valid    (p_valid),
        .instr          (p_instr),
        .instr_pc       (p_pc),
        .instr_ready    (p_rdy),
        .perf_fetched   (p_fetched),
        .perf_flushed   (p_flushed)
    );

    initial begin
        p_rvalid = 1'b0;
        p_rdata  = 32'h0;
    end

    always @(posedge clk) begin
        p_rvalid <= p_req;
        p_rdata  <= wd(p_addr);
    end
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word for an address: distinct per address so mixups are visible
    function automatic logic [31:0] wd(input logic [31:0] a);
        return a ^ 32'hA500_0013;
    endfunction

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_val;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic redir, input logic [31:0] rpc,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_pc);
        vec_t v;
        v.rv = rv; v.rd = rd; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
        tv.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rv, input logic [31:0] rd, input logic rdy,
                         input logic redir, input logic [31:0] rpc);
        imem_rvalid    = rv;
        imem_rdata     = rd;
        instr_ready    = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_val, input logic [31:0] e_pc);
        chk({tag, ".req"}, 32'(imem_req), 32'(e_req));
        if (e_req) chk({tag, ".addr"}, imem_addr, e_addr);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(e_val));
        chk({tag, ".pc"}, instr_pc, e_val ? e_pc : 32'h0);
        chk({tag, ".instr"}, instr, e_val ? wd(e_pc) : 32'h0);
    endtask

    task automatic expect_zero(input string tag);
        chk({tag, ".req"}, 32'(imem_req), 32'h0);
        chk({tag, ".addr"}, imem_addr, 32'h0);
        chk({tag, ".valid"}, 32'(instr_valid), 32'h0);
        chk({tag, ".instr"}, instr, 32'h0);
        chk({tag, ".pc"}, instr_pc, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle 0 is the first cycle after reset release; 1-cycle memory unless noted
        add(0, 32'h0,       1, 0, 0,          1, 32'h000, 0, 0);
        add(1, wd(32'h000), 1, 0, 0,          1, 32'h004, 0, 0);
        add(1, wd(32'h004), 1, 0, 0,          1, 32'h008, 1, 32'h000);
        add(1, wd(32'h008), 1, 0, 0,          1, 32'h00C, 1, 32'h004);
        // Stall downstream: buffer fills to two entries and fetching stops
        add(1, wd(32'h00C), 0, 0, 0,          0, 0,       1, 32'h008);
        add(0, 32'h0,       0, 0, 0,          0, 0,       1, 32'h008);
        add(0, 32'h0,       1, 0, 0,          1, 32'h010, 1, 32'h008);
        add(1, wd(32'h010), 1, 0, 0,          1, 32'h014, 1, 32'h00C);
        // Redirect with 0x14 outstanding (latency 3): stale reply dropped
        add(0, 32'h0,       0, 1, 32'h103,    0, 0,       1, 32'h010);
        add(0, 32'h0,       0, 0, 0,          0, 0,       0, 0);
        add(1, wd(32'h014), 0, 0, 0,          0, 0,       0, 0);
        add(0, 32'h0,       0, 0, 0,          1, 32'h100, 0, 0);
        add(0, 32'h0,       0, 0, 0,          0, 0,       0, 0);
        add(1, wd(32'h100), 1, 0, 0,          1, 32'h104, 0, 0);
        add(0, 32'h0,       0, 0, 0,          0, 0,       1, 32'h100);
        // Redirect together with rvalid, one entry buffered and ready high
        add(1, wd(32'h104), 1, 1, 32'h200,    0, 0,       1, 32'h100);
        add(0, 32'h0,       1, 0, 0,          1, 32'h200, 0, 0);
        add(1, wd(32'h200), 1, 0, 0,          1, 32'h204, 0, 0);
        add(0, 32'h0,       1, 0, 0,          0, 0,       1, 32'h200);
        add(1, wd(32'h204), 1, 0, 0,          1, 32'h208, 0, 0);
        // Back-to-back redirects, second one lands in DRAIN and wins
        add(0, 32'h0,       1, 1, 32'h300,    0, 0,       1, 32'h204);
        add(0, 32'h0,       1, 1, 32'h401,    0, 0,       0, 0);
        add(1, wd(32'h208), 1, 0, 0,          0, 0,       0, 0);
        add(0, 32'h0,       1, 0, 0,          1, 32'h400, 0, 0);
        add(0, 32'h0,       0, 0, 0,          0, 0,       0, 0);
        add(1, wd(32'h400), 0, 0, 0,          1, 32'h404, 0, 0);
        add(1, wd(32'h404), 0, 0, 0,          0, 0,       1, 32'h400);
        // Spurious rvalid in IDLE must not enter the buffer
        add(1, 32'hDEAD_BEEF, 0, 0, 0,        0, 0,       1, 32'h400);
        add(0, 32'h0,       1, 0, 0,          1, 32'h408, 1, 32'h400);
        add(0, 32'h0,       1, 0, 0,          0, 0,       1, 32'h404);
        // Ready while empty does nothing
        add(0, 32'h0,       1, 0, 0,          0, 0,       0, 0);
        add(1, wd(32'h408), 1, 0, 0,          1, 32'h40C, 0, 0);
        add(0, 32'h0,       0, 0, 0,          0, 0,       1, 32'h408);

        rst_n = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0);
`ifdef FETCH_PERF_EN
        p_rst_n = 1'b0;
        p_redir = 1'b0;
        p_rdy   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        expect_zero("reset");

        foreach (tv[i]) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b1;
            drive(tv[i].rv, tv[i].rd, tv[i].rdy, tv[i].redir, tv[i].rpc);
            #1;
            expect_out($sformatf("v%0d", i), tv[i].e_req, tv[i].e_addr, tv[i].e_val, tv[i].e_pc);
        end

        // Reset in the middle of a fetch to 0x20
        @(negedge clk); drive(1, wd(32'h40C), 1, 1, 32'h20); #1;
        expect_out("rs0", 0, 0, 1, 32'h408);
        @(negedge clk); drive(0, 32'h0, 0, 0, 32'h0); #1;
        expect_out("rs1", 1, 32'h20, 0, 0);
        @(negedge clk); drive(0, 32'h0, 0, 0, 32'h0); #1;
        expect_out("rs2", 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b0; #1;
        expect_zero("rs_low");
        // Late reply lands in the first cycle after release and is ignored
        @(negedge clk); rst_n = 1'b1; drive(1, 32'hBAD0_0000, 1, 0, 32'h0); #1;
        expect_out("rs3", 1, 32'h0, 0, 0);
        @(negedge clk); drive(0, 32'h0, 1, 0, 32'h0); #1;
        expect_out("rs4", 0, 0, 0, 0);
        @(negedge clk); drive(1, wd(32'h0), 1, 0, 32'h0); #1;
        expect_out("rs5", 1, 32'h4, 0, 0);
        @(negedge clk); drive(0, 32'h0, 1, 0, 32'h0); #1;
        expect_out("rs6", 0, 0, 1, 32'h0);

`ifdef FETCH_PERF_EN
        // Five pushes, then a redirect with two buffered and one live reply
        chk("perf.fetched_rst", p_fetched, 32'd0);
        chk("perf.flushed_rst", p_flushed, 32'd0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) p_rst_n = 1'b1;
            p_rdy   = (c >= 3 && c <= 5);
            p_redir = (c == 6);
            #1;
            if (c == 6) begin
                chk("perf.fetched_pre", p_fetched, 32'd5);
                chk("perf.flushed_pre", p_flushed, 32'd0);
            end
        end
        chk("perf.fetched", p_fetched, 32'd5);
        chk("perf.flushed", p_flushed, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
